// File: rtl/ilb_xfer_engine_if.sv
// Bundle of the request, ILB handshake and IM_Window signals of ilb_xfer_engine.
// Handshakes: a transfer occurs on a rising edge where rts && rtr; the engine holds its data
// stable while its own rts is high, and it never raises rts and rtr together.
interface ilb_xfer_engine_if #(
  parameter int DATA_W   = 8,
  parameter int NUM_TAPS = 6
);
  logic                       send_en;
  logic [DATA_W-1:0]          uart_byte;
  logic                       pix_rts;
  logic                       pix_rtr;
  logic [DATA_W-1:0]          pix_out;
  logic                       tap_rtr;
  logic                       tap_rts;
  logic [NUM_TAPS*DATA_W-1:0] ilb_taps;
  logic [NUM_TAPS*DATA_W-1:0] win_taps;
  logic                       byte_sent;
  logic                       taps_valid;
  logic                       busy;
  logic                       err;

  modport master (
    input  send_en, uart_byte, pix_rtr, tap_rts, ilb_taps,
    output pix_rts, pix_out, tap_rtr, win_taps, byte_sent, taps_valid, busy, err
  );

  modport slave (
    output send_en, uart_byte, pix_rtr, tap_rts, ilb_taps,
    input  pix_rts, pix_out, tap_rtr, win_taps, byte_sent, taps_valid, busy, err
  );
endinterface

// File: rtl/ilb_xfer_engine.sv
// Pushes one pixel to the ILB, pulls NUM_TAPS column pixels back and holds them for IM_Window.
// Optional handshake watchdog enabled by defining ILB_TIMEOUT_EN.
module ilb_xfer_engine #(
  parameter int DATA_W      = 8,
  parameter int NUM_TAPS    = 6,
  parameter int HOLD_CYC    = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,
  ilb_xfer_engine_if.master  bus,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, READ = 2'd2, HOLD = 2'd3} state_t;

  localparam int HC_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYC - 1);

  if (HOLD_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("ilb_xfer_engine: HOLD_CYC and TIMEOUT_CYC must be at least 1");
  end

  state_t                     state;
  logic [HC_W-1:0]            hold_cnt;
  logic                       pix_rts_q;
  logic                       tap_rtr_q;
  logic [DATA_W-1:0]          pix_out_q;
  logic [NUM_TAPS*DATA_W-1:0] win_taps_q;
  logic                       byte_sent_q;
  logic                       taps_valid_q;
  logic                       busy_q;

`ifdef ILB_TIMEOUT_EN
  localparam int WD_RAW = $clog2(TIMEOUT_CYC + 1);
  localparam int WD_W   = (WD_RAW < 8) ? 8 : ((WD_RAW > 16) ? 16 : WD_RAW);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wd_cnt;
  logic            err_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      pix_rts_q    <= 1'b0;
      tap_rtr_q    <= 1'b0;
      pix_out_q    <= '0;
      win_taps_q   <= '0;
      byte_sent_q  <= 1'b0;
      taps_valid_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef ILB_TIMEOUT_EN
      wd_cnt       <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      byte_sent_q <= 1'b0;
`ifdef ILB_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.send_en) begin
            state     <= SEND;
            pix_rts_q <= 1'b1;
            pix_out_q <= bus.uart_byte;
            busy_q    <= 1'b1;
`ifdef ILB_TIMEOUT_EN
            wd_cnt    <= '0;
`endif
          end
        end
        SEND: begin
          // tap_rtr rises on the same edge pix_rts falls, so the two are never high together
          if (pix_rts_q && bus.pix_rtr) begin
            state       <= READ;
            pix_rts_q   <= 1'b0;
            tap_rtr_q   <= 1'b1;
            byte_sent_q <= 1'b1;
`ifdef ILB_TIMEOUT_EN
            wd_cnt      <= '0;
`endif
          end
`ifdef ILB_TIMEOUT_EN
          else if (wd_cnt == WD_LAST) begin
            state     <= IDLE;
            pix_rts_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        READ: begin
          if (tap_rtr_q && bus.tap_rts) begin
            state        <= HOLD;
            tap_rtr_q    <= 1'b0;
            win_taps_q   <= bus.ilb_taps;
            taps_valid_q <= 1'b1;
            hold_cnt     <= '0;
          end
`ifdef ILB_TIMEOUT_EN
          else if (wd_cnt == WD_LAST) begin
            state     <= IDLE;
            tap_rtr_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            taps_valid_q <= 1'b0;
            hold_cnt     <= '0;
            // a request on the last hold cycle chains straight into the next transaction
            if (bus.send_en) begin
              state     <= SEND;
              pix_rts_q <= 1'b1;
              pix_out_q <= bus.uart_byte;
`ifdef ILB_TIMEOUT_EN
              wd_cnt    <= '0;
`endif
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.pix_rts    = pix_rts_q;
  assign bus.tap_rtr    = tap_rtr_q;
  assign bus.pix_out    = pix_out_q;
  assign bus.win_taps   = win_taps_q;
  assign bus.byte_sent  = byte_sent_q;
  assign bus.taps_valid = taps_valid_q;
  assign bus.busy       = busy_q;
  assign state_dbg      = state;

`ifdef ILB_TIMEOUT_EN
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule
